// File: rtl/video_in_pkg.sv
// Shared video-in definitions: pack geometry defaults
// and the pack reader state encoding.
package video_in_pkg;

   localparam int DATA_SIZE_DEF    = 8;
   localparam int NB_PACK_ADDR_DEF = 4;

   typedef enum logic [1:0] {
      IDLE,
      READ,
      FLUSH
   } rd_state_t;

endpackage

// File: rtl/pack_skid.sv
// Two-entry skid FIFO absorbing RAM read data so the
// stream can stall without losing in-flight pixels.
module pack_skid
   import video_in_pkg::*;
#(
   parameter int DATA_SIZE = DATA_SIZE_DEF
)
(
   input  logic                 clk,
   input  logic                 nRST,
   input  logic                 push,
   input  logic [DATA_SIZE-1:0] push_data,
   input  logic                 pop,
   output logic [DATA_SIZE-1:0] head,
   output logic [1:0]           count
);

   logic [DATA_SIZE-1:0] mem [2];
   logic                 wr_ptr;
   logic                 rd_ptr;

   assign head = mem[rd_ptr];

   // storage, pointers and occupancy; the caller never
   // pushes when full nor pops when empty
   always_ff @(posedge clk or negedge nRST) begin
      if (!nRST) begin
         mem[0] <= '0;
         mem[1] <= '0;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= ~wr_ptr;
         end
         if (pop)
            rd_ptr <= ~rd_ptr;
         count <= count + {1'b0, push} - {1'b0, pop};
      end
   end

endmodule

// File: rtl/pack_reader.sv
// Drains one pack of a double-buffered RAM into a pixel stream.
// Optional pack counter output enabled by PACK_READER_CNT_EN.
module pack_reader
   import video_in_pkg::*;
#(
   parameter int DATA_SIZE    = DATA_SIZE_DEF,
   parameter int NB_PACK_ADDR = NB_PACK_ADDR_DEF
)
(
   input  logic                    clk,
   input  logic                    nRST,
   input  logic                    pack_rdy,
   input  logic                    pack_bank,
   output logic                    rd_en,
   output logic                    rd_bank,
   output logic [NB_PACK_ADDR-1:0] rd_addr,
   input  logic [DATA_SIZE-1:0]    rd_data,
   output logic                    pack_done,
   output logic [DATA_SIZE-1:0]    out_data,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic                    out_last
`ifdef PACK_READER_CNT_EN
   ,
   output logic [15:0]             pack_cnt
`endif
);

   localparam logic [NB_PACK_ADDR-1:0] LAST_ADDR = '1;

   rd_state_t          state;
   logic               rd_pend;
   logic               rd_pend_last;
   logic [1:0]         fifo_cnt;
   logic [DATA_SIZE:0] head;
   logic               pop;
   logic [2:0]         occ;

   // a pop always has a FIFO entry behind it, so occ never underflows
   assign pop       = out_valid & out_ready;
   assign occ       = {1'b0, fifo_cnt} + {2'b0, rd_pend} - {2'b0, pop};
   assign rd_en     = (state == READ) && (occ < 3'd2);
   assign out_valid = (fifo_cnt != 2'd0);
   assign out_data  = out_valid ? head[DATA_SIZE-1:0] : '0;
   assign out_last  = out_valid & head[DATA_SIZE];

   // track the read whose data returns next cycle, tagging the last pixel
   always_ff @(posedge clk or negedge nRST) begin
      if (!nRST) begin
         rd_pend      <= 1'b0;
         rd_pend_last <= 1'b0;
      end else begin
         rd_pend      <= rd_en;
         rd_pend_last <= rd_en && (rd_addr == LAST_ADDR);
      end
   end

   pack_skid #(
      .DATA_SIZE (DATA_SIZE + 1)
   ) u_skid (
      .clk       (clk),
      .nRST      (nRST),
      .push      (rd_pend),
      .push_data ({rd_pend_last, rd_data}),
      .pop       (pop),
      .head      (head),
      .count     (fifo_cnt)
   );

   // pack sequencing: accept, issue reads, wait for the last pixel to leave
   always_ff @(posedge clk or negedge nRST) begin
      if (!nRST) begin
         state     <= IDLE;
         rd_bank   <= 1'b0;
         rd_addr   <= '0;
         pack_done <= 1'b0;
      end else begin
         pack_done <= 1'b0;
         unique case (state)
            IDLE: begin
               // the pack_done cycle is skipped so the writer can drop pack_rdy
               if (pack_rdy && !pack_done) begin
                  rd_bank <= pack_bank;
                  rd_addr <= '0;
                  state   <= READ;
               end
            end
            READ: begin
               if (rd_en) begin
                  rd_addr <= rd_addr + 1'b1;
                  if (rd_addr == LAST_ADDR)
                     state <= FLUSH;
               end
            end
            FLUSH: begin
               if (pop && out_last) begin
                  pack_done <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef PACK_READER_CNT_EN
   // count completed packs, wrapping naturally at 16 bits
   always_ff @(posedge clk or negedge nRST) begin
      if (!nRST)
         pack_cnt <= 16'd0;
      else if (pack_done)
         pack_cnt <= pack_cnt + 16'd1;
   end
`endif

endmodule

// File: tb/tb_pack_reader.sv
// Bench for pack_reader: RAM model, stream monitor and per-scenario
// checks against expected pixel sequences built from RAM contents.
module tb_pack_reader;

   localparam int DW = 8;
   localparam int AW = 4;
   localparam int N  = 16;

   logic          clk = 1'b0;
   logic          nRST;
   logic          pack_rdy;
   logic          pack_bank;
   logic          rd_en;
   logic          rd_bank;
   logic [AW-1:0] rd_addr;
   logic [DW-1:0] rd_data;
   logic          pack_done;
   logic [DW-1:0] out_data;
   logic          out_valid;
   logic          out_ready;
   logic          out_last;
`ifdef PACK_READER_CNT_EN
   logic [15:0]   pack_cnt;
`endif

   int total = 0;
   int bad   = 0;

   logic [DW-1:0] ram [2][N];

   always #5 clk = ~clk;

   pack_reader #(
      .DATA_SIZE    (DW),
      .NB_PACK_ADDR (AW)
   ) dut (
      .clk       (clk),
      .nRST      (nRST),
      .pack_rdy  (pack_rdy),
      .pack_bank (pack_bank),
      .rd_en     (rd_en),
      .rd_bank   (rd_bank),
      .rd_addr   (rd_addr),
      .rd_data   (rd_data),
      .pack_done (pack_done),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_last  (out_last)
`ifdef PACK_READER_CNT_EN
      ,
      .pack_cnt  (pack_cnt)
`endif
   );

   // synchronous-read RAM: data one cycle after the strobe
   always @(posedge clk)
      if (rd_en)
         rd_data <= ram[rd_bank][rd_addr];

   // stream monitor: records transfers and protocol violations
   int            cyc = 0;
   logic [DW-1:0] got_q [$];
   bit            last_q [$];
   int            cyc_q [$];
   int            done_q [$];
   bit            bank_q [$];
   int            bcyc_q [$];
   int            issued = 0;
   int            xfers = 0;
   int            stall_err = 0;
   int            outst_err = 0;
   logic          prev_stall = 1'b0;
   logic [DW-1:0] prev_data = '0;
   logic          prev_last = 1'b0;

   always @(negedge clk) begin
      cyc <= cyc + 1;
      if (!nRST) begin
         issued     <= 0;
         xfers      <= 0;
         prev_stall <= 1'b0;
      end else begin
         if (out_valid && out_ready) begin
            got_q.push_back(out_data);
            last_q.push_back(out_last);
            cyc_q.push_back(cyc);
         end
         if (pack_done)
            done_q.push_back(cyc);
         if (rd_en && rd_addr == '0) begin
            bank_q.push_back(rd_bank);
            bcyc_q.push_back(cyc);
         end
         if (prev_stall && (out_valid !== 1'b1 || out_data !== prev_data
                            || out_last !== prev_last))
            stall_err <= stall_err + 1;
         prev_stall <= out_valid && !out_ready;
         prev_data  <= out_data;
         prev_last  <= out_last;
         if ((issued + int'(rd_en)) - (xfers + int'(out_valid && out_ready)) > 2)
            outst_err <= outst_err + 1;
         issued <= issued + int'(rd_en);
         xfers  <= xfers + int'(out_valid && out_ready);
      end
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: sim time exceeded");
      $fatal(1, "watchdog");
   end

   // mode 0: ready held 1; 1: ready 1,0,0,1; 2: random ready
   task automatic drive(input int npacks, input int mode, input bit b0,
                        input bit b1, input int budget, output int t0);
      int d0;
      int k0;
      d0 = done_q.size();
      k0 = bank_q.size();
      @(posedge clk);
      #1;
      pack_bank = b0;
      pack_rdy  = 1'b1;
      out_ready = (mode == 2) ? ($urandom_range(0, 3) != 0) : 1'b1;
      t0 = cyc;
      for (int i = 1; i < budget; i++) begin
         @(posedge clk);
         #1;
         case (mode)
            1:       out_ready = (i % 4 == 0) || (i % 4 == 3);
            2:       out_ready = ($urandom_range(0, 3) != 0);
            default: out_ready = 1'b1;
         endcase
         if (done_q.size() >= d0 + npacks) begin
            pack_rdy = 1'b0;
            break;
         end
         if (done_q.size() > d0)
            pack_bank = b1;
         else if (mode == 2 && bank_q.size() > k0)
            pack_bank = 1'($urandom_range(0, 1));
      end
      pack_rdy = 1'b0;
   endtask

   task automatic test_reset();
      nRST      = 1'b0;
      pack_rdy  = 1'b0;
      pack_bank = 1'b0;
      out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      total++;
      if ({rd_en, rd_bank, rd_addr, pack_done, out_valid, out_last, out_data} !== '0) begin
         bad++;
         $display("FAIL reset_outputs: got en=%b bank=%b addr=%0h done=%b v=%b l=%b d=%0h want all 0",
                  rd_en, rd_bank, rd_addr, pack_done, out_valid, out_last, out_data);
      end
      @(negedge clk);
      nRST = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      total++;
      if ({rd_en, out_valid, pack_done} !== 3'b000) begin
         bad++;
         $display("FAIL idle_no_pack: got en=%b v=%b done=%b want 0 0 0",
                  rd_en, out_valid, pack_done);
      end
   endtask

   task automatic test_stream();
      int b0, d0, k0, n, t0;
      for (int i = 0; i < N; i++)
         ram[0][i] = DW'(i);
      b0 = got_q.size();
      d0 = done_q.size();
      k0 = bank_q.size();
      drive(1, 0, 1'b0, 1'b0, 200, t0);
      n = got_q.size() - b0;
      total++;
      if (n != N) begin
         bad++;
         $display("FAIL stream_count: got %0d want %0d", n, N);
      end
      for (int i = 0; i < N && i < n; i++) begin
         total++;
         if (got_q[b0+i] !== DW'(i) || last_q[b0+i] !== (i == N - 1)
             || cyc_q[b0+i] != t0 + 3 + i) begin
            bad++;
            $display("FAIL stream_px%0d: got d=%0h l=%b cyc=%0d want d=%0h l=%b cyc=%0d",
                     i, got_q[b0+i], last_q[b0+i], cyc_q[b0+i], i, i == N - 1, t0 + 3 + i);
         end
      end
      total++;
      if (done_q.size() != d0 + 1 || (n == N && done_q[d0] != cyc_q[b0+N-1] + 1)) begin
         bad++;
         $display("FAIL stream_done: got %0d pulses want 1 one cycle after last",
                  done_q.size() - d0);
      end
      total++;
      if (bank_q.size() != k0 + 1 || bank_q[k0] !== 1'b0) begin
         bad++;
         $display("FAIL stream_bank: got %0d starts want 1 on bank 0", bank_q.size() - k0);
      end
   endtask

   task automatic test_backpressure();
      int b0, d0, n, t0, se, oe;
      for (int i = 0; i < N; i++)
         ram[0][i] = DW'(i);
      b0 = got_q.size();
      d0 = done_q.size();
      se = stall_err;
      oe = outst_err;
      drive(1, 1, 1'b0, 1'b0, 300, t0);
      n = got_q.size() - b0;
      total++;
      if (n != N) begin
         bad++;
         $display("FAIL bp_count: got %0d want %0d", n, N);
      end
      for (int i = 0; i < N && i < n; i++) begin
         total++;
         if (got_q[b0+i] !== DW'(i) || last_q[b0+i] !== (i == N - 1)) begin
            bad++;
            $display("FAIL bp_px%0d: got d=%0h l=%b want d=%0h l=%b",
                     i, got_q[b0+i], last_q[b0+i], i, i == N - 1);
         end
      end
      total++;
      if (stall_err != se || outst_err != oe) begin
         bad++;
         $display("FAIL bp_protocol: got stall_err=%0d outst_err=%0d want 0 0",
                  stall_err - se, outst_err - oe);
      end
      total++;
      if (done_q.size() != d0 + 1) begin
         bad++;
         $display("FAIL bp_done: got %0d want 1", done_q.size() - d0);
      end
   endtask

   task automatic test_back_to_back();
      int b0, d0, k0, n, t0;
      logic [DW-1:0] exp_q [$];
      for (int i = 0; i < N; i++) begin
         ram[0][i] = DW'(i);
         ram[1][i] = DW'(16 + i);
      end
      for (int b = 0; b < 2; b++)
         for (int i = 0; i < N; i++)
            exp_q.push_back(ram[b][i]);
      b0 = got_q.size();
      d0 = done_q.size();
      k0 = bank_q.size();
      drive(2, 0, 1'b0, 1'b1, 300, t0);
      n = got_q.size() - b0;
      total++;
      if (n != 2 * N) begin
         bad++;
         $display("FAIL b2b_count: got %0d want %0d", n, 2 * N);
      end
      for (int i = 0; i < 2 * N && i < n; i++) begin
         total++;
         if (got_q[b0+i] !== exp_q[i] || last_q[b0+i] !== (i % N == N - 1)) begin
            bad++;
            $display("FAIL b2b_px%0d: got d=%0h l=%b want d=%0h l=%b",
                     i, got_q[b0+i], last_q[b0+i], exp_q[i], i % N == N - 1);
         end
      end
      total++;
      if (done_q.size() != d0 + 2) begin
         bad++;
         $display("FAIL b2b_done: got %0d pulses want 2", done_q.size() - d0);
      end
      total++;
      if (bank_q.size() != k0 + 2 || bank_q[k0] !== 1'b0 || bank_q[k0+1] !== 1'b1) begin
         bad++;
         $display("FAIL b2b_banks: got %0d starts want bank 0 then bank 1",
                  bank_q.size() - k0);
      end
      total++;
      if (bank_q.size() >= k0 + 2 && done_q.size() >= d0 + 1
          && bcyc_q[k0+1] != done_q[d0] + 2) begin
         bad++;
         $display("FAIL b2b_holdoff: got 2nd start cyc %0d want %0d",
                  bcyc_q[k0+1], done_q[d0] + 2);
      end
   endtask

   task automatic test_reset_mid();
      int b0, d0, b1, n, t0;
      for (int i = 0; i < N; i++) begin
         ram[0][i] = DW'(8'h40 + i);
         ram[1][i] = DW'($urandom_range(0, 255));
      end
      b0 = got_q.size();
      d0 = done_q.size();
      @(posedge clk);
      #1;
      pack_bank = 1'b0;
      pack_rdy  = 1'b1;
      out_ready = 1'b1;
      for (int i = 0; i < 100 && got_q.size() - b0 < 5; i++) begin
         @(posedge clk);
         #1;
      end
      nRST = 1'b0;
      #1;
      total++;
      if (got_q.size() - b0 != 5) begin
         bad++;
         $display("FAIL rst_mid_pre: got %0d transfers want 5", got_q.size() - b0);
      end
      total++;
      if ({rd_en, rd_bank, rd_addr, pack_done, out_valid, out_last, out_data} !== '0) begin
         bad++;
         $display("FAIL rst_mid_outputs: got en=%b bank=%b addr=%0h v=%b d=%0h want all 0",
                  rd_en, rd_bank, rd_addr, out_valid, out_data);
      end
      pack_bank = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      nRST = 1'b1;
      b1 = got_q.size();
      drive(1, 0, 1'b1, 1'b1, 200, t0);
      total++;
      if (done_q.size() != d0 + 1) begin
         bad++;
         $display("FAIL rst_mid_done: got %0d pulses want 1", done_q.size() - d0);
      end
      n = got_q.size() - b1;
      total++;
      if (n != N) begin
         bad++;
         $display("FAIL rst_mid_count: got %0d want %0d", n, N);
      end
      for (int i = 0; i < N && i < n; i++) begin
         total++;
         if (got_q[b1+i] !== ram[1][i]) begin
            bad++;
            $display("FAIL rst_mid_px%0d: got %0h want %0h", i, got_q[b1+i], ram[1][i]);
         end
      end
   endtask

   task automatic test_random();
      int b0, d0, n, t0, se, oe;
      bit b;
      logic [DW-1:0] exp_q [$];
      for (int p = 0; p < 3; p++) begin
         b = 1'($urandom_range(0, 1));
         for (int i = 0; i < N; i++)
            ram[b][i] = DW'($urandom_range(0, 255));
         exp_q.delete();
         for (int i = 0; i < N; i++)
            exp_q.push_back(ram[b][i]);
         b0 = got_q.size();
         d0 = done_q.size();
         se = stall_err;
         oe = outst_err;
         drive(1, 2, b, b, 600, t0);
         n = got_q.size() - b0;
         total++;
         if (n != N || done_q.size() != d0 + 1) begin
            bad++;
            $display("FAIL rand%0d_count: got %0d px %0d done want %0d px 1 done",
                     p, n, done_q.size() - d0, N);
         end
         for (int i = 0; i < N && i < n; i++) begin
            total++;
            if (got_q[b0+i] !== exp_q[i] || last_q[b0+i] !== (i == N - 1)) begin
               bad++;
               $display("FAIL rand%0d_px%0d: got d=%0h l=%b want d=%0h l=%b",
                        p, i, got_q[b0+i], last_q[b0+i], exp_q[i], i == N - 1);
            end
         end
         total++;
         if (stall_err != se || outst_err != oe) begin
            bad++;
            $display("FAIL rand%0d_protocol: got stall_err=%0d outst_err=%0d want 0 0",
                     p, stall_err - se, outst_err - oe);
         end
      end
   endtask

`ifdef PACK_READER_CNT_EN
   task automatic test_cnt_wrap();
      int t0;
      force dut.pack_cnt = 16'hFFFF;
      @(posedge clk);
      #1;
      release dut.pack_cnt;
      drive(1, 0, 1'b0, 1'b0, 200, t0);
      #1;
      total++;
      if (pack_cnt !== 16'h0000) begin
         bad++;
         $display("FAIL cnt_wrap: got %0h want 0", pack_cnt);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_stream();
      test_backpressure();
      test_back_to_back();
      test_reset_mid();
      test_random();
`ifdef PACK_READER_CNT_EN
      test_cnt_wrap();
`endif
      repeat (5) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pack_reader.md
PACK_READER -- requirements
Module: pack_reader

Interface
REQ-001 Parameter DATA_SIZE, 8, pixel width in bits.
REQ-002 Parameter NB_PACK_ADDR, 4, pack address width; pack length = 2**NB_PACK_ADDR pixels.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 nRST  input  1  reset, asynchronous, active-low.
REQ-005 pack_rdy  input  1  level, a completed pack waits in bank pack_bank.
REQ-006 pack_bank  input  1  bank (0/1) holding the waiting pack; sampled only when a pack is accepted.
REQ-007 rd_en  output  1  read strobe to the double-buffer RAMs.
REQ-008 rd_bank  output  1  bank being read; held constant for a whole pack.
REQ-009 rd_addr  output  NB_PACK_ADDR  pixel address within the pack.
REQ-010 rd_data  input  DATA_SIZE  RAM read data, valid exactly one cycle after rd_en.
REQ-011 pack_done  output  1  one-cycle pulse, bank rd_bank fully drained and free for the writer.
REQ-012 out_data  output  DATA_SIZE  pixel stream data.
REQ-013 out_valid  output  1  out_data valid.
REQ-014 out_ready  input  1  downstream accepts; a transfer occurs when out_valid and out_ready are both 1.
REQ-015 out_last  output  1  marks pixel 2**NB_PACK_ADDR-1 of the pack, qualified by out_valid.

Function
REQ-016 FSM states: IDLE, READ, FLUSH.
REQ-017 IDLE: pack_rdy=1 (and no holdoff) -> latch pack_bank into rd_bank, clear rd_addr, go to READ.
REQ-018 READ: rd_en=1 only when skid occupancy plus in-flight reads minus the current-cycle pop is below 2; rd_addr increments by 1 after each issued read.
REQ-019 READ: the read at address 2**NB_PACK_ADDR-1 moves to FLUSH; rd_addr wraps to 0; no rd_en is issued in FLUSH or IDLE.
REQ-020 Each returned rd_data is pushed into a 2-entry skid FIFO the cycle it returns; out_data/out_valid are driven from the FIFO head.
REQ-021 Ordering: pixels leave in address order 0..2**NB_PACK_ADDR-1; no pixel is dropped or duplicated under any out_ready pattern.
REQ-022 Latency: with out_ready=1, the first out_valid occurs 3 cycles after the IDLE cycle in which pack_rdy is sampled high.
REQ-023 Throughput: with out_ready held at 1, a pack streams in 2**NB_PACK_ADDR consecutive cycles.
REQ-024 Backpressure: out_ready=0 holds out_data/out_valid/out_last stable; issuing stalls once the FIFO plus in-flight reads reach 2.
REQ-025 FLUSH: on the out_last transfer, pulse pack_done for one cycle and return to IDLE.
REQ-026 Holdoff: IDLE ignores pack_rdy in the cycle immediately after pack_done, so the writer can clear it.
REQ-027 pack_rdy or pack_bank changes during READ/FLUSH are ignored.

Reset
REQ-028 nRST low: state IDLE; FIFO empty; rd_en, rd_bank, rd_addr, pack_done, out_valid, out_last, out_data all 0.
REQ-029 Reset mid-pack abandons the pack with no pack_done; after release, the reader restarts at pixel 0 of whichever bank pack_rdy/pack_bank then present.

Configuration
REQ-030 With PACK_READER_CNT_EN defined, output pack_cnt [15:0] exists: reset 0, +1 on each pack_done, wraps 0xFFFF->0.
REQ-031 Without PACK_READER_CNT_EN, pack_cnt and its counter are absent; all other behaviour is identical.

Structure
REQ-032 Shared package video_in_pkg holds DATA_SIZE, NB_PACK_ADDR defaults and the reader state enum typedef.
REQ-033 The skid FIFO is sub-module pack_skid (depth 2, push/pop/count, parameter DATA_SIZE).

Verification
REQ-034 NB_PACK_ADDR=4, bank 0 filled 0x00..0x0F, pack_rdy=1, out_ready=1 -> 0x00..0x0F on 16 consecutive cycles, out_last with 0x0F, pack_done the next cycle.
REQ-035 out_ready toggling 1,0,0,1 repeating -> exact sequence 0x00..0x0F, outputs stable while stalled, never more than 2 reads outstanding.
REQ-036 Back-to-back packs bank0 then bank1 (0x10..0x1F), pack_rdy held -> rd_bank 0 then 1, 32 ordered pixels, two pack_done pulses, no restart of bank 0 during holdoff.
REQ-037 nRST asserted after the 5th pixel transfer -> all outputs 0 immediately; after release a new pack streams from pixel 0.
REQ-038 PACK_READER_CNT_EN defined, pack_cnt preloaded to 0xFFFF via 65535 packs (or forced) -> 0x0000 after the next pack_done.
